// File: rtl/m68k_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// m68k_bus_arbiter_if
// Groups the handshake between the 68K bus arbiter, the PiStorm transaction
// engine and the external BR/BG/BGACK bus-master wires.
//
// Signals:
//   txn_req       engine has a pending transaction
//   txn_active    engine is inside S1..S7 of a bus cycle
//   txn_gnt       engine may leave S0 on the next c7m falling edge
//   m68k_br_n     raw (asynchronous) bus request from external masters
//   m68k_bgack_n  raw (asynchronous) bus grant acknowledge
//   m68k_bg_n     bus grant driven to external masters
//   bus_release   tristate every PiStorm-driven bus signal
//   ext_owner     an external master currently owns the bus
//
// Modports:
//   slave   the arbiter side
//   master  the environment side (engine + bus pins)
// -----------------------------------------------------------------------------
interface m68k_bus_arbiter_if;
   logic txn_req;
   logic txn_active;
   logic txn_gnt;
   logic m68k_br_n;
   logic m68k_bgack_n;
   logic m68k_bg_n;
   logic bus_release;
   logic ext_owner;

   modport slave (
      input  txn_req,
      input  txn_active,
      input  m68k_br_n,
      input  m68k_bgack_n,
      output txn_gnt,
      output m68k_bg_n,
      output bus_release,
      output ext_owner
   );

   modport master (
      output txn_req,
      output txn_active,
      output m68k_br_n,
      output m68k_bgack_n,
      input  txn_gnt,
      input  m68k_bg_n,
      input  bus_release,
      input  ext_owner
   );
endinterface

// File: rtl/m68k_bus_arbiter.sv
// -----------------------------------------------------------------------------
// m68k_bus_arbiter
// Decides who owns the 68K bus: the internal Pi-driven transaction engine or an
// external master (Amiga DMA, accelerator) using the 68000 BR/BG/BGACK
// three-wire protocol. Everything runs in the c125m domain; the 7 MHz bus
// clock arrives as one-cycle rising/falling strobes.
//
// Ports:
//   c125m        system clock
//   rst          synchronous, active-high reset
//   c7m_rising   strobe on each synchronized M68K_CLK rising edge
//   c7m_falling  strobe on each synchronized M68K_CLK falling edge
//   bus          arbiter side of m68k_bus_arbiter_if (engine + BR/BG/BGACK)
//   arb_state    current state code (IDLE=0 PEND=1 GRANTED=2 EXT=3 RECLAIM=4)
//   timeout_cnt  saturating count of grants withdrawn for lack of BGACK
// -----------------------------------------------------------------------------
module m68k_bus_arbiter #(
   parameter int GRANT_TIMEOUT  = 8,
   parameter int HOLDOFF_CYCLES = 2
) (
   input  logic                     c125m,
   input  logic                     rst,
   input  logic                     c7m_rising,
   input  logic                     c7m_falling,
   m68k_bus_arbiter_if.slave        bus,
   output logic [2:0]               arb_state,
   output logic [7:0]               timeout_cnt
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PEND    = 3'd1,
      GRANTED = 3'd2,
      EXT     = 3'd3,
      RECLAIM = 3'd4
   } state_t;

   localparam logic [7:0] GRANT_LOAD   = GRANT_TIMEOUT[7:0];
   localparam logic [3:0] HOLDOFF_LOAD = HOLDOFF_CYCLES[3:0];

   state_t     state;
   logic [1:0] br_sync;
   logic [1:0] bgack_sync;
   logic       br_s;
   logic       bgack_s;
   logic [7:0] grant_cnt;
   logic [3:0] holdoff_cnt;
   logic       bg_n_q;
   logic       release_q;
   logic       owner_q;
   logic       gnt_q;
   logic [7:0] timeouts_q;

   // The external wires are asynchronous, so decisions are taken on the second
   // synchronizer stage; both chains preset to the inactive (high) level.
   assign br_s    = br_sync[1];
   assign bgack_s = bgack_sync[1];

   // All outputs are registered copies of the FSM's own flops.
   assign bus.txn_gnt     = gnt_q;
   assign bus.m68k_bg_n   = bg_n_q;
   assign bus.bus_release = release_q;
   assign bus.ext_owner   = owner_q;
   assign arb_state       = state;
   assign timeout_cnt     = timeouts_q;

   // Single arbitration FSM. Transitions and BG changes happen only on a c7m
   // rising strobe; the grant watchdog counts c7m falling strobes so that a
   // grant lasts exactly GRANT_TIMEOUT bus clocks before it can be withdrawn.
   // txn_gnt is driven together with every transition so the engine sees it
   // drop on the very edge that leaves IDLE. BR outranks the engine: IDLE
   // moves to PEND whenever BR is seen, regardless of txn_req. RECLAIM keeps
   // the bus tristated for HOLDOFF_CYCLES after BGACK releases, then spends one
   // more bus clock before handing the bus back (or straight to PEND when
   // another DMA request is already waiting).
   always_ff @(posedge c125m) begin
      if (rst) begin
         br_sync     <= 2'b11;
         bgack_sync  <= 2'b11;
         state       <= IDLE;
         grant_cnt   <= 8'd0;
         holdoff_cnt <= 4'd0;
         bg_n_q      <= 1'b1;
         release_q   <= 1'b0;
         owner_q     <= 1'b0;
         gnt_q       <= 1'b0;
         timeouts_q  <= 8'd0;
      end else begin
         br_sync    <= {br_sync[0], bus.m68k_br_n};
         bgack_sync <= {bgack_sync[0], bus.m68k_bgack_n};

         case (state)
            IDLE: begin
               if (c7m_rising && !br_s) begin
                  state <= PEND;
                  gnt_q <= 1'b0;
               end else begin
                  gnt_q <= 1'b1;
               end
            end

            PEND: begin
               if (c7m_rising) begin
                  if (br_s) begin
                     state <= IDLE;
                     gnt_q <= 1'b1;
                  end else if (!bus.txn_active) begin
                     state     <= GRANTED;
                     bg_n_q    <= 1'b0;
                     grant_cnt <= GRANT_LOAD;
                  end
               end
            end

            GRANTED: begin
               if (c7m_rising) begin
                  if (!bgack_s) begin
                     state     <= EXT;
                     bg_n_q    <= 1'b1;
                     release_q <= 1'b1;
                     owner_q   <= 1'b1;
                  end else if (br_s) begin
                     state  <= IDLE;
                     bg_n_q <= 1'b1;
                     gnt_q  <= 1'b1;
                  end else if (grant_cnt == 8'd0) begin
                     state  <= IDLE;
                     bg_n_q <= 1'b1;
                     gnt_q  <= 1'b1;
                     if (timeouts_q != 8'hFF) begin
                        timeouts_q <= timeouts_q + 8'd1;
                     end
                  end
               end else if (c7m_falling && grant_cnt != 8'd0) begin
                  grant_cnt <= grant_cnt - 8'd1;
               end
            end

            EXT: begin
               if (c7m_rising && bgack_s) begin
                  state       <= RECLAIM;
                  holdoff_cnt <= HOLDOFF_LOAD;
                  owner_q     <= 1'b0;
               end
            end

            RECLAIM: begin
               if (c7m_rising) begin
                  if (holdoff_cnt != 4'd0) begin
                     holdoff_cnt <= holdoff_cnt - 4'd1;
                     if (holdoff_cnt == 4'd1) begin
                        release_q <= 1'b0;
                     end
                  end else if (br_s) begin
                     state <= IDLE;
                     gnt_q <= 1'b1;
                  end else begin
                     state <= PEND;
                  end
               end
            end

            default: begin
               state     <= IDLE;
               bg_n_q    <= 1'b1;
               release_q <= 1'b0;
               owner_q   <= 1'b0;
               gnt_q     <= 1'b0;
            end
         endcase
      end
   end

endmodule
